// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI transaction arbiter:
//   - state_t          : arbiter FSM state encoding
//   - CFG_*            : bit positions inside the per-requester config byte
//                        {mode, len, cpol, cpha, div[2:0], rsvd}
//   - WDOG_LIMIT/W     : XFER watchdog limit in clk cycles and counter width
//   - force_leader()   : returns a config byte with the mode bit set (leader)
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_XFER  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int CFG_MODE_BIT = 7;
    localparam int CFG_LEN_BIT  = 6;
    localparam int CFG_CPOL_BIT = 5;
    localparam int CFG_CPHA_BIT = 4;
    localparam int CFG_DIV_MSB  = 3;
    localparam int CFG_DIV_LSB  = 1;
    localparam int CFG_RSVD_BIT = 0;

    localparam int WDOG_LIMIT = 4096;
    localparam int WDOG_W     = $clog2(WDOG_LIMIT);

    // The arbiter always acts as SPI leader, whatever the requester asked for.
    function automatic logic [7:0] force_leader(input logic [7:0] cfg);
        logic [7:0] res;
        res               = cfg;
        res[CFG_MODE_BIT] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts at ptr+1 and wraps
// from NREQ-1 back to 0, so the previous winner has the lowest priority.
// Ports:
//   req [NREQ-1:0]  in   request vector
//   ptr [IW-1:0]    in   index of the last winner
//   gnt [NREQ-1:0]  out  one-hot pick (all zero when req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] hi_req;

    // Requests strictly above the pointer win first; otherwise wrap around
    // and take the lowest request overall. x & -x isolates the lowest set bit.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        hi_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (IW'(i) > ptr);
        end
        hi_req = req & hi_mask;
        if (hi_req != '0) begin
            gnt = hi_req & (~hi_req + 1'b1);
        end else begin
            gnt = req & (~req + 1'b1);
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// -----------------------------------------------------------------------------
// spi_txn_arbiter
// Shares one SPI leader core between NREQ requesters. A winner is picked
// round-robin, its chip select is framed by GAP idle cycles on each side of
// the core transfer, and done is pulsed back to it with the received word.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req       [NREQ]         level requests, held until done
//   req_cfg   [NREQ*8]       per-requester config byte
//   req_txd   [NREQ*16]      per-requester transmit word
//   gnt       [NREQ]         one-hot grant, SETUP through DONE
//   done      [NREQ]         one-cycle completion pulse to the winner
//   rxd       [16]           received word, updated in XFER, held afterwards
//   core_cfg/core_txd        latched config (mode forced) / transmit word
//   core_start               one-cycle start pulse to the core
//   core_done/core_rxd       completion pulse and receive word from the core
//   cs_n      [NREQ]         active-low chip selects
// -----------------------------------------------------------------------------
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GAP  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*8-1:0]    req_cfg,
    input  logic [NREQ*16-1:0]   req_txd,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [15:0]          rxd,
    output logic [7:0]           core_cfg,
    output logic [15:0]          core_txd,
    output logic                 core_start,
    input  logic                 core_done,
    input  logic [15:0]          core_rxd,
    output logic [NREQ-1:0]      cs_n
);

    localparam int          IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);
    localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(WDOG_LIMIT - 1);

    state_t            state;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     pick_idx;
    logic [NREQ-1:0]   pick;
    logic [NREQ-1:0]   win_oh;
    logic [3:0]        gap_cnt;
    logic [WDOG_W-1:0] wd_cnt;
    logic              cs_active;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    // Outputs decode straight from the state register so that an
    // asynchronous reset releases cs_n and core_start in the same instant.
    assign win_oh     = NREQ'(1) << winner;
    assign cs_active  = (state == ST_SETUP) || (state == ST_START) ||
                        (state == ST_XFER)  || (state == ST_HOLD);
    assign gnt        = (state != ST_IDLE) ? win_oh : '0;
    assign done       = (state == ST_DONE) ? win_oh : '0;
    assign cs_n       = cs_active ? ~win_oh : '1;
    assign core_start = (state == ST_START);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            winner   <= '0;
            rr_ptr   <= IW'(NREQ - 1);
            gap_cnt  <= '0;
            wd_cnt   <= '0;
            core_cfg <= '0;
            core_txd <= '0;
            rxd      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != '0) begin
                        winner   <= pick_idx;
                        core_cfg <= force_leader(req_cfg[pick_idx*8 +: 8]);
                        core_txd <= req_txd[pick_idx*16 +: 16];
                        gap_cnt  <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_START;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_START: begin
                    wd_cnt <= '0;
                    state  <= ST_XFER;
                end
                ST_XFER: begin
                    // A silent core is abandoned after WDOG_LIMIT cycles and
                    // reported to the requester as an all-ones word.
                    if (core_done) begin
                        rxd   <= core_rxd;
                        state <= ST_HOLD;
                    end else if (wd_cnt == WD_LAST) begin
                        rxd   <= 16'hFFFF;
                        state <= ST_HOLD;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_DONE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    rr_ptr <= winner;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_txn_arbiter
// Scoreboard bench: each expected transaction is queued when its request is
// driven and popped when the DUT pulses done. A small core model answers
// core_start with core_done after core_delay cycles (rxd = txd ^ core_mask),
// or never when core_enable is low.
// -----------------------------------------------------------------------------
module tb_spi_txn_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] req_cfg;
    logic [NREQ*16-1:0] req_txd;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [15:0]       rxd;
    logic [7:0]        core_cfg;
    logic [15:0]       core_txd;
    logic              core_start;
    logic              core_done;
    logic [15:0]       core_rxd;
    logic [NREQ-1:0]   cs_n;

    spi_txn_arbiter #(.NREQ(NREQ), .GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_cfg    (req_cfg),
        .req_txd    (req_txd),
        .gnt        (gnt),
        .done       (done),
        .rxd        (rxd),
        .core_cfg   (core_cfg),
        .core_txd   (core_txd),
        .core_start (core_start),
        .core_done  (core_done),
        .core_rxd   (core_rxd),
        .cs_n       (cs_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [7:0]  cfg;
        logic [15:0] txd;
        logic [15:0] rxd;
    } exp_t;

    exp_t sb[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   start_count = 0;
    int   done_count  = 0;

    // core model controls
    bit          core_enable = 1'b1;
    int          core_delay  = 5;
    logic [15:0] core_mask   = 16'hFFFF;
    bit          stray_req   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Core model
    initial begin : core_model
        int          cd;
        bit          stray_ack;
        logic [15:0] seen_txd;
        cd        = -1;
        stray_ack = 1'b0;
        seen_txd  = '0;
        core_done = 1'b0;
        core_rxd  = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (rst) begin
                cd = -1;
            end else if (core_start) begin
                seen_txd = core_txd;
                cd = core_enable ? core_delay : -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (cd == 0) begin
                core_done = 1'b1;
                core_rxd  = seen_txd ^ core_mask;
                cd        = -1;
            end else if (stray_req != stray_ack) begin
                core_done = 1'b1;
                core_rxd  = 16'hDEAD;
                stray_ack = stray_req;
            end
        end
    end

    // Monitor / scoreboard consumer
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            check("onehot", {29'd0, $onehot0(~cs_n), $onehot0(gnt), $onehot0(done)}, 32'd7);
            if (core_start) begin
                start_count++;
                if (sb.size() != 0) begin
                    check("start_cfg",  core_cfg, sb[0].cfg);
                    check("start_txd",  core_txd, sb[0].txd);
                    check("start_cs_n", cs_n, 4'b1111 ^ (4'b0001 << sb[0].idx));
                    check("start_gnt",  gnt, 4'b0001 << sb[0].idx);
                end
            end
            if (done != '0) begin
                done_count++;
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_idx",  done, 4'b0001 << e.idx);
                    check("done_rxd",  rxd, e.rxd);
                    check("done_cs_n", cs_n, 4'b1111);
                end
            end
        end
    end

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (done == '0 && cycles < budget);
        if (done == '0) check("done_timeout", 0, 1);
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_start && n < budget);
        if (!core_start) check("start_timeout", 0, 1);
    endtask

    task automatic push(input int idx, input logic [7:0] cfg, input logic [15:0] txd,
                        input logic [15:0] rx);
        exp_t e;
        e.idx = idx; e.cfg = cfg; e.txd = txd; e.rxd = rx;
        sb.push_back(e);
    endtask

    initial begin : global_guard
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : stim
        int lat;
        int d0;
        int s0;
        int          rr_idx [5] = '{0, 1, 2, 3, 0};
        logic [7:0]  rr_cfg [5] = '{8'hB0, 8'hCF, 8'hB0, 8'h81, 8'hB0};
        logic [15:0] rr_txd [5] = '{16'hA000, 16'hA101, 16'hA202, 16'hA303, 16'hA000};
        logic [15:0] rr_rxd [5] = '{16'h5FFF, 16'h5EFE, 16'h5DFD, 16'h5CFC, 16'h5FFF};

        rst = 1'b1; req = '0; req_cfg = '0; req_txd = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt",        gnt, 0);
        check("rst_done",       done, 0);
        check("rst_cs_n",       cs_n, 4'b1111);
        check("rst_core_start", core_start, 0);
        check("rst_core_cfg",   core_cfg, 0);
        check("rst_core_txd",   core_txd, 0);
        check("rst_rxd",        rxd, 0);
        rst = 1'b0;
        @(negedge clk);

        // Round-robin with all requests held; req 0 cfg 0x30 checks mode forcing.
        req_cfg = {8'h01, 8'hB0, 8'h4F, 8'h30};
        for (int i = 0; i < NREQ; i++) req_txd[i*16 +: 16] = 16'hA000 | 16'(i * 16'h0101);
        core_delay = 5; core_mask = 16'hFFFF;
        for (int k = 0; k < 5; k++) push(rr_idx[k], rr_cfg[k], rr_txd[k], rr_rxd[k]);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(200, lat);
            check("rr_order", done, 4'b0001 << rr_idx[k]);
        end
        req = '0;
        repeat (3) @(negedge clk);
        check("rr_sb_empty", sb.size(), 0);

        // core_done while idle must be ignored
        stray_req = ~stray_req;
        repeat (3) @(negedge clk);
        check("stray_rxd", rxd, 16'h5FFF);
        check("stray_gnt", gnt, 0);

        // Single request on index 2
        core_delay = 20; core_mask = 16'h3C99;
        req_cfg[2*8 +: 8]   = 8'hB0;
        req_txd[2*16 +: 16] = 16'h00A5;
        push(2, 8'hB0, 16'h00A5, 16'h3C3C);
        s0  = start_count;
        req = 4'b0100;
        wait_done(200, lat);
        req = '0;
        check("single_latency", lat, 2*GAP + 2 + 20);
        check("single_rxd", rxd, 16'h3C3C);
        @(negedge clk);
        check("single_starts", start_count - s0, 1);
        check("single_cs_idle", cs_n, 4'b1111);

        // Watchdog: core never answers
        core_enable = 1'b0;
        req_cfg[3*8 +: 8]   = 8'h7E;
        req_txd[3*16 +: 16] = 16'hBEEF;
        push(3, 8'hFE, 16'hBEEF, 16'hFFFF);
        req = 4'b1000;
        wait_done(5000, lat);
        req = '0;
        check("wdog_latency", lat, 2*GAP + 2 + 4096);
        check("wdog_rxd", rxd, 16'hFFFF);
        @(negedge clk);
        check("wdog_cs_idle", cs_n, 4'b1111);
        core_enable = 1'b1;

        // Early drop of req[1] during XFER
        core_delay = 10; core_mask = 16'h0F0F;
        req_txd[1*16 +: 16] = 16'h1234;
        push(1, 8'hCF, 16'h1234, 16'h1D3B);
        d0  = done_count;
        req = 4'b0010;
        wait_start(100);
        @(negedge clk);
        req = '0;
        wait_done(100, lat);
        repeat (20) @(negedge clk);
        check("drop_done_once", done_count, d0 + 1);

        // Reset during XFER of index 2 (pointer is 1 here)
        core_enable = 1'b0;
        d0  = done_count;
        req = 4'b0100;
        wait_start(100);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_xfer_cs_n",  cs_n, 4'b1111);
        check("rst_xfer_gnt",   gnt, 0);
        check("rst_xfer_start", core_start, 0);
        check("rst_xfer_done",  done, 0);
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_xfer_no_done", done_count, d0);

        // First request after reset goes to index 0
        core_enable = 1'b1; core_delay = 5; core_mask = 16'hFFFF;
        req_txd[0 +: 16] = 16'h5555;
        push(0, 8'hB0, 16'h5555, 16'hAAAA);
        req = 4'b1011;
        wait_done(200, lat);
        req = '0;
        check("post_rst_winner", done, 4'b0001);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
